multicycle_decoder: RTL and testbench

MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

---
 rtl/cpu_ctrl_pkg.sv | 26 ++
 rtl/alu_decoder.sv | 33 +++
 rtl/multicycle_decoder.sv | 125 ++++++++++++
 tb/tb_multicycle_decoder.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared FSM states, ALU codes and datapath mux selects
package cpu_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMRD, MEMWB, MEMWR, BRANCH
  } state_t;
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;
  localparam logic [2:0] ALU_MOV = 3'd5;
  localparam logic SRCA_RN = 1'b0;
  localparam logic SRCA_PC = 1'b1;
  localparam logic ADR_PC = 1'b0;
  localparam logic ADR_RES = 1'b1;
  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;
  localparam logic [1:0] SRCB_4 = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA = 2'b01;
  localparam logic [1:0] RES_ALU = 2'b10;
  localparam logic [1:0] OP_DP = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: data-processing cmd to ALU code, flag-write enables and legality
module alu_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int EXT_OPS = 1
) (
  input  logic [4:0] funct,
  output logic [2:0] alu_ctl,
  output logic [1:0] flags,
  output logic       no_wb,
  output logic       legal
);
  localparam logic EXT = (EXT_OPS != 0);
  logic s;
  always_comb begin
    alu_ctl = ALU_ADD;
    legal = 1'b1;
    no_wb = 1'b0;
    case (funct[4:1])
      4'b0100: alu_ctl = ALU_ADD;
      4'b0010: alu_ctl = ALU_SUB;
      4'b0000: alu_ctl = ALU_AND;
      4'b1100: alu_ctl = ALU_ORR;
      4'b0001: begin alu_ctl = ALU_EOR; legal = EXT; end
      4'b1101: begin alu_ctl = ALU_MOV; legal = EXT; end
      4'b1010: begin alu_ctl = ALU_SUB; legal = EXT; no_wb = 1'b1; end
      4'b1000: begin alu_ctl = ALU_AND; legal = EXT; no_wb = 1'b1; end
      default: legal = 1'b0;
    endcase
    s = funct[0] | no_wb;
    flags = {s, s & (alu_ctl == ALU_ADD || alu_ctl == ALU_SUB)};
  end
endmodule

// File: rtl/multicycle_decoder.sv
// multicycle_decoder: multicycle CPU control FSM driving datapath selects and writes
module multicycle_decoder
  import cpu_ctrl_pkg::*;
#(
  parameter int ALU_W = 3,
  parameter int EXT_OPS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       op,
  input  logic [5:0]       funct,
  input  logic [3:0]       rd,
  input  logic             cond_ex,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_w,
  output logic             mem_w,
  output logic             adr_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic [1:0]       reg_src,
  output logic [ALU_W-1:0] alu_control,
  output logic [1:0]       flag_w,
  output logic             illegal
);
  state_t state, next;
  logic [2:0] dp_alu, alu3;
  logic [1:0] dp_flags;
  logic dp_no_wb, dp_legal, pc_dst;
  alu_decoder #(.EXT_OPS(EXT_OPS)) u_alu (
    .funct(funct[4:0]),
    .alu_ctl(dp_alu),
    .flags(dp_flags),
    .no_wb(dp_no_wb),
    .legal(dp_legal)
  );
  assign pc_dst = (rd == 4'hf);
  assign imm_src = (op == OP_MEM) ? 2'b01 : (op == OP_BR) ? 2'b10 : 2'b00;
  assign reg_src = (op == OP_BR) ? 2'b01 : (op == OP_MEM && !funct[0]) ? 2'b10 : 2'b00;
  assign alu_control = ALU_W'(alu3);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FETCH;
    else state <= next;
  always_comb begin
    next = state;
    ir_write = 1'b0;
    pc_write = 1'b0;
    reg_w = 1'b0;
    mem_w = 1'b0;
    adr_src = ADR_PC;
    alu_src_a = SRCA_RN;
    alu_src_b = SRCB_REG;
    result_src = RES_ALUOUT;
    alu3 = ALU_ADD;
    flag_w = 2'b00;
    illegal = 1'b0;
    case (state)
      FETCH: begin
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_4;
        result_src = RES_ALU;
        ir_write = mem_ready;
        pc_write = mem_ready;
        next = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_4;
        result_src = RES_ALU;
        illegal = (op == OP_ILL) || (op == OP_DP && !dp_legal);
        next = illegal ? FETCH : (op == OP_MEM) ? MEMADR : (op == OP_BR) ? BRANCH :
               funct[5] ? EXECI : EXECR;
      end
      EXECR, EXECI: begin
        alu_src_b = (state == EXECI) ? SRCB_IMM : SRCB_REG;
        alu3 = dp_alu;
        flag_w = cond_ex ? dp_flags : 2'b00;
        next = dp_no_wb ? FETCH : ALUWB;
      end
      ALUWB: begin
        reg_w = cond_ex;
        pc_write = cond_ex & pc_dst;
        next = FETCH;
      end
      MEMADR: begin
        alu_src_b = SRCB_IMM;
        next = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        adr_src = ADR_RES;
        next = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        result_src = RES_RDATA;
        reg_w = cond_ex;
        pc_write = cond_ex & pc_dst;
        next = FETCH;
      end
      MEMWR: begin
        adr_src = ADR_RES;
        mem_w = cond_ex;
        next = mem_ready ? FETCH : MEMWR;
      end
      BRANCH: begin
        alu_src_a = SRCA_PC;
        alu_src_b = SRCB_IMM;
        result_src = RES_ALU;
        pc_write = cond_ex;
        next = FETCH;
      end
      default: next = FETCH;
    endcase
    if (!rst_n) begin
      ir_write = 1'b0;
      pc_write = 1'b0;
      reg_w = 1'b0;
      mem_w = 1'b0;
      flag_w = 2'b00;
      illegal = 1'b0;
    end
  end
endmodule

// File: tb/tb_multicycle_decoder.sv
// tb_multicycle_decoder: scoreboard bench for the multicycle control FSM
module tb_multicycle_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] op = 2'b00;
  logic [5:0] funct = 6'b0;
  logic [3:0] rd = 4'b0;
  logic cond_ex = 1'b1;
  logic mem_ready = 1'b1;
  logic ir_write, pc_write, reg_w, mem_w, adr_src, alu_src_a, illegal;
  logic [1:0] alu_src_b, result_src, imm_src, reg_src, flag_w;
  logic [2:0] alu_control;
  logic ir_write0, pc_write0, reg_w0, mem_w0, adr_src0, alu_src_a0, illegal0;
  logic [1:0] alu_src_b0, result_src0, imm_src0, reg_src0, flag_w0;
  logic [3:0] alu_control0;
  logic [20:0] out, out0;
  typedef struct {
    string name;
    bit sel;
    logic [20:0] e;
  } item_t;
  item_t sb[$];
  item_t it;
  int vectors = 0;
  int errs = 0;
  always #5 clk = ~clk;
  multicycle_decoder dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rd(rd), .cond_ex(cond_ex),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .reg_w(reg_w),
    .mem_w(mem_w), .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .result_src(result_src), .imm_src(imm_src), .reg_src(reg_src),
    .alu_control(alu_control), .flag_w(flag_w), .illegal(illegal)
  );
  multicycle_decoder #(.ALU_W(4), .EXT_OPS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .rd(rd), .cond_ex(cond_ex),
    .mem_ready(mem_ready), .ir_write(ir_write0), .pc_write(pc_write0), .reg_w(reg_w0),
    .mem_w(mem_w0), .adr_src(adr_src0), .alu_src_a(alu_src_a0), .alu_src_b(alu_src_b0),
    .result_src(result_src0), .imm_src(imm_src0), .reg_src(reg_src0),
    .alu_control(alu_control0), .flag_w(flag_w0), .illegal(illegal0)
  );
  assign out = {1'b0, ir_write, pc_write, reg_w, mem_w, adr_src, alu_src_a, alu_src_b,
                result_src, imm_src, reg_src, alu_control, flag_w, illegal};
  assign out0 = {alu_control0[3], ir_write0, pc_write0, reg_w0, mem_w0, adr_src0, alu_src_a0,
                 alu_src_b0, result_src0, imm_src0, reg_src0, alu_control0[2:0], flag_w0, illegal0};
  function automatic logic [20:0] v(input int irw, pcw, rw, mw, adr, sa, sb_, rs, is, rsr, ac, fw, ill);
    return {1'b0, 1'(irw), 1'(pcw), 1'(rw), 1'(mw), 1'(adr), 1'(sa), 2'(sb_), 2'(rs), 2'(is),
            2'(rsr), 3'(ac), 2'(fw), 1'(ill)};
  endfunction
  task automatic ins(input int o, input int f, input int r, input int c);
    op = 2'(o);
    funct = 6'(f);
    rd = 4'(r);
    cond_ex = 1'(c);
  endtask
  task automatic cyc(input string nm, input int m, input logic [20:0] e, input logic [20:0] e0);
    mem_ready = 1'(m);
    sb.push_back('{name: nm, sel: 1'b0, e: e});
    sb.push_back('{name: {nm, "_x0"}, sel: 1'b1, e: e0});
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    while (sb.size() > 0) begin
      it = sb.pop_front();
      vectors++;
      if ((it.sel ? out0 : out) !== it.e) begin
        errs++;
        $display("FAIL %s: got %b expected %b", it.name, it.sel ? out0 : out, it.e);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [20:0] f0, f1, d;
    rst_n = 1'b0;
    ins(0, 'h09, 1, 1);
    f0 = v(0,0,0,0,0,1,2,2,0,0,0,0,0);
    f1 = v(1,1,0,0,0,1,2,2,0,0,0,0,0);
    d = v(0,0,0,0,0,1,2,2,0,0,0,0,0);
    cyc("reset", 1, f0, f0);
    rst_n = 1'b1;
    cyc("fetch_hold", 0, f0, f0);
    cyc("adds_fetch", 1, f1, f1);
    cyc("adds_decode", 1, d, d);
    cyc("adds_execr", 1, v(0,0,0,0,0,0,0,0,0,0,0,3,0), v(0,0,0,0,0,0,0,0,0,0,0,3,0));
    cyc("adds_aluwb", 1, v(0,0,1,0,0,0,0,0,0,0,0,0,0), v(0,0,1,0,0,0,0,0,0,0,0,0,0));
    ins(0, 'b101000, 15, 1);
    cyc("addpc_fetch", 1, f1, f1);
    cyc("addpc_decode", 1, d, d);
    cyc("addpc_execi", 1, v(0,0,0,0,0,0,1,0,0,0,0,0,0), v(0,0,0,0,0,0,1,0,0,0,0,0,0));
    cyc("addpc_aluwb", 1, v(0,1,1,0,0,0,0,0,0,0,0,0,0), v(0,1,1,0,0,0,0,0,0,0,0,0,0));
    ins(0, 'b010100, 0, 1);
    cyc("cmp_fetch", 1, f1, f1);
    cyc("cmp_decode", 0, d, d | 21'd1);
    cyc("cmp_execr", 0, v(0,0,0,0,0,0,0,0,0,0,1,3,0), f0);
    cyc("cmp_no_aluwb", 0, f0, f0);
    ins(0, 'b000010, 4, 1);
    cyc("eor_fetch", 1, f1, f1);
    cyc("eor_decode", 0, d, d | 21'd1);
    cyc("eor_execr", 0, v(0,0,0,0,0,0,0,0,0,0,4,0,0), f0);
    cyc("eor_aluwb", 0, v(0,0,1,0,0,0,0,0,0,0,0,0,0), f0);
    cyc("eor_sync", 0, f0, f0);
    ins(3, 0, 0, 1);
    cyc("op3_fetch", 1, f1, f1);
    cyc("op3_decode", 1, d | 21'd1, d | 21'd1);
    cyc("op3_next_fetch", 0, f0, f0);
    ins(1, 'b000001, 2, 1);
    cyc("ldr_fetch", 1, v(1,1,0,0,0,1,2,2,1,0,0,0,0), v(1,1,0,0,0,1,2,2,1,0,0,0,0));
    cyc("ldr_decode", 1, v(0,0,0,0,0,1,2,2,1,0,0,0,0), v(0,0,0,0,0,1,2,2,1,0,0,0,0));
    cyc("ldr_memadr", 1, v(0,0,0,0,0,0,1,0,1,0,0,0,0), v(0,0,0,0,0,0,1,0,1,0,0,0,0));
    for (int i = 0; i < 4; i++)
      cyc("ldr_memrd", i == 3 ? 1 : 0, v(0,0,0,0,1,0,0,0,1,0,0,0,0), v(0,0,0,0,1,0,0,0,1,0,0,0,0));
    cyc("ldr_memwb", 1, v(0,0,1,0,0,0,0,1,1,0,0,0,0), v(0,0,1,0,0,0,0,1,1,0,0,0,0));
    ins(1, 0, 3, 0);
    cyc("strn_fetch", 1, v(1,1,0,0,0,1,2,2,1,2,0,0,0), v(1,1,0,0,0,1,2,2,1,2,0,0,0));
    cyc("strn_decode", 1, v(0,0,0,0,0,1,2,2,1,2,0,0,0), v(0,0,0,0,0,1,2,2,1,2,0,0,0));
    cyc("strn_memadr", 1, v(0,0,0,0,0,0,1,0,1,2,0,0,0), v(0,0,0,0,0,0,1,0,1,2,0,0,0));
    cyc("strn_memwr_wait", 0, v(0,0,0,0,1,0,0,0,1,2,0,0,0), v(0,0,0,0,1,0,0,0,1,2,0,0,0));
    cyc("strn_memwr_done", 1, v(0,0,0,0,1,0,0,0,1,2,0,0,0), v(0,0,0,0,1,0,0,0,1,2,0,0,0));
    cyc("strn_back_fetch", 0, v(0,0,0,0,0,1,2,2,1,2,0,0,0), v(0,0,0,0,0,1,2,2,1,2,0,0,0));
    ins(1, 0, 3, 1);
    cyc("strr_fetch", 1, v(1,1,0,0,0,1,2,2,1,2,0,0,0), v(1,1,0,0,0,1,2,2,1,2,0,0,0));
    cyc("strr_decode", 1, v(0,0,0,0,0,1,2,2,1,2,0,0,0), v(0,0,0,0,0,1,2,2,1,2,0,0,0));
    cyc("strr_memadr", 1, v(0,0,0,0,0,0,1,0,1,2,0,0,0), v(0,0,0,0,0,0,1,0,1,2,0,0,0));
    cyc("strr_memwr", 0, v(0,0,0,1,1,0,0,0,1,2,0,0,0), v(0,0,0,1,1,0,0,0,1,2,0,0,0));
    rst_n = 1'b0;
    cyc("strr_reset", 0, v(0,0,0,0,0,1,2,2,1,2,0,0,0), v(0,0,0,0,0,1,2,2,1,2,0,0,0));
    rst_n = 1'b1;
    cyc("strr_release", 0, v(0,0,0,0,0,1,2,2,1,2,0,0,0), v(0,0,0,0,0,1,2,2,1,2,0,0,0));
    cyc("strr_refetch", 1, v(1,1,0,0,0,1,2,2,1,2,0,0,0), v(1,1,0,0,0,1,2,2,1,2,0,0,0));
    cyc("strr_redecode", 1, v(0,0,0,0,0,1,2,2,1,2,0,0,0), v(0,0,0,0,0,1,2,2,1,2,0,0,0));
    cyc("strr_readr", 1, v(0,0,0,0,0,0,1,0,1,2,0,0,0), v(0,0,0,0,0,0,1,0,1,2,0,0,0));
    cyc("strr_rewr", 1, v(0,0,0,1,1,0,0,0,1,2,0,0,0), v(0,0,0,1,1,0,0,0,1,2,0,0,0));
    ins(2, 0, 0, 1);
    cyc("b_fetch", 1, v(1,1,0,0,0,1,2,2,2,1,0,0,0), v(1,1,0,0,0,1,2,2,2,1,0,0,0));
    cyc("b_decode", 1, v(0,0,0,0,0,1,2,2,2,1,0,0,0), v(0,0,0,0,0,1,2,2,2,1,0,0,0));
    cyc("b_branch", 1, v(0,1,0,0,0,1,1,2,2,1,0,0,0), v(0,1,0,0,0,1,1,2,2,1,0,0,0));
    cyc("b_next_fetch", 1, v(1,1,0,0,0,1,2,2,2,1,0,0,0), v(1,1,0,0,0,1,2,2,2,1,0,0,0));
    for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      errs++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
